siso_shift_sched: RTL
=====================

// Module: siso_shift_sched
// PURPOSE
//   Two-requester scheduler for the 4-bit serial-out shift path.
//   Each requester offers a parallel word on a valid/ready handshake. A round-robin
//   arbiter grants one requester, loads its word into the shift register and shifts
//   it out MSB-first on sout, one bit per clock, with a frame-enable strobe.
//   An inter-frame gap follows each frame. Sits between producer blocks and the serial line.
// PARAMETERS
//   WIDTH  4  bits per frame (>=2); also sets the bit-counter width, $clog2(WIDTH)
//   GAP    1  idle cycles after each frame (0 allowed: return straight to IDLE)
// PORTS
//   clk         in   1      single clock, all logic on posedge
//   rst         in   1      synchronous, active-high reset
//   req0_valid  in   1      requester 0 has a word
//   req0_data   in   WIDTH  requester 0 word, held stable while valid && !ready
//   req0_ready  out  1      requester 0 word accepted this cycle (when valid)
//   req1_valid  in   1      requester 1 has a word
//   req1_data   in   WIDTH  requester 1 word
//   req1_ready  out  1      requester 1 word accepted this cycle (when valid)
//   sout        out  1      serial data, MSB first
//   sout_en     out  1      high while sout carries a frame bit
//   grant_id    out  1      requester owning the current/last frame
//   done        out  1      one-cycle pulse with the last bit of a frame
//   busy        out  1      state != IDLE
// BEHAVIOUR
//   - Reset (rst=1 at posedge):
//     - state=IDLE; sout=0, sout_en=0, done=0, grant_id=0.
//     - last_grant=1, so requester 0 wins the first tie.
//     - req*_ready are forced 0 while rst=1.
//   - FSM IDLE -> SHIFT -> GAP -> IDLE. With GAP=0: SHIFT -> IDLE.
//   - IDLE, arbitration:
//     - Only one valid: that requester is granted.
//     - Both valid: grant the requester != last_grant.
//     - reqN_ready = (state==IDLE) && !rst && granted==N. Combinational, same cycle as valid.
//     - At most one ready is high per cycle.
//   - Handshake at edge T (valid && ready):
//     - shreg <= data; cnt <= 0; grant_id/last_grant <= N; state <= SHIFT.
//   - SHIFT, cycles T+1..T+WIDTH:
//     - sout = shreg[WIDTH-1]; sout_en=1; shreg shifts left, zero fill; cnt increments.
//     - In cycle T+WIDTH (cnt==WIDTH-1): done=1; next state GAP, or IDLE if GAP=0.
//   - GAP: sout=0, sout_en=0; stays GAP cycles (gap counter), then IDLE.
//   - First bit latency: 1 cycle after the handshake. Min frame period: WIDTH+GAP+1 cycles.
//   - Valid during SHIFT/GAP: ready stays 0, the word is held by the requester, nothing is lost.
//   - Valid withdrawn before ready: no transfer, no state change.
//   - sout, sout_en and done are registered outputs (no combinational path from the inputs).
//   - Reset mid-frame: the frame is aborted.
//     - Next cycle sout=0, sout_en=0; no done pulse.
//     - Arbitration pointer returns to its reset value.
// TESTING (WIDTH=4, GAP=1)
//   1. rst=1 for 2 cycles with both valid=1
//      -> both ready=0; sout=0, sout_en=0, done=0, busy=0, grant_id=0.
//   2. req0 only, data=4'b1011, handshake at T
//      -> sout=1,0,1,1 on T+1..T+4 with sout_en=1; done=1 only at T+4;
//         sout_en=0 at T+5; busy=0 and ready0 may rise at T+6.
//   3. Both valid continuously, req0=4'hA, req1=4'h5
//      -> grants alternate 0,1,0,1; frames 1010,0101,... every 6 cycles.
//   4. req1 only after a req0 frame
//      -> req1 granted on the first IDLE cycle; grant_id=1.
//   5. req1 asserts valid during a req0 frame
//      -> ready1=0 until IDLE; word then shifted intact, no bits dropped.
//   6. rst pulsed during 2nd bit of frame 4'b1100
//      -> next cycle sout=0, sout_en=0, no done;
//         with both valid afterwards, req0 granted first.

Source files
------------

// File: rtl/siso_shift_sched_if.sv
// Requester-side bundle for siso_shift_sched: two valid/ready/data producers.
// master = producer side, slave = scheduler side.
interface siso_shift_sched_if #(
  parameter int WIDTH = 4
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;

  modport master (
    output req0_valid, req0_data,
    output req1_valid, req1_data,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_data,
    input  req1_valid, req1_data,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/siso_shift_sched.sv
// Two-requester round-robin scheduler feeding a WIDTH-bit MSB-first serial line.
// Ports: clk, rst (sync, active-high), rq (requester handshakes), sout, sout_en, grant_id, done, busy.
module siso_shift_sched #(
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic              clk,
  input  logic              rst,
  siso_shift_sched_if.slave rq,
  output logic              sout,
  output logic              sout_en,
  output logic              grant_id,
  output logic              done,
  output logic              busy
);

  localparam int CW = $clog2(WIDTH);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CW-1:0] CLAST = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GLAST = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAPS
  } state_t;

  state_t           state;
  state_t           nstate;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic [GW-1:0]    gcnt;
  logic             last_grant;
  logic             gnt0;
  logic             gnt1;
  logic             hs;
  logic             hs_id;
  logic             idle;
  logic             last_bit;

  assign idle     = (state == IDLE);
  assign last_bit = (cnt == CLAST);

  // On a tie the requester that did not own the previous frame wins.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rq.req0_valid && rq.req1_valid) begin
      gnt0 = last_grant;
      gnt1 = !last_grant;
    end else begin
      gnt0 = rq.req0_valid;
      gnt1 = rq.req1_valid;
    end
  end

  assign rq.req0_ready = idle && !rst && gnt0;
  assign rq.req1_ready = idle && !rst && gnt1;
  assign hs            = rq.req0_ready || rq.req1_ready;
  assign hs_id         = rq.req1_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nstate;
    end
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: begin
        if (hs) nstate = SHIFT;
      end
      SHIFT: begin
        if (last_bit) nstate = (GAP == 0) ? IDLE : GAPS;
      end
      GAPS: begin
        if (gcnt == GLAST) nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  // Zero fill means shreg is all-zero once a frame has fully left,
  // so sout idles low without extra clearing.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg      <= '0;
      cnt        <= '0;
      gcnt       <= '0;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (hs) begin
            shreg      <= hs_id ? rq.req1_data : rq.req0_data;
            cnt        <= '0;
            grant_id   <= hs_id;
            last_grant <= hs_id;
          end
        end
        SHIFT: begin
          shreg <= {shreg[WIDTH-2:0], 1'b0};
          cnt   <= cnt + 1'b1;
          gcnt  <= '0;
        end
        GAPS: begin
          gcnt <= gcnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode registers only; no path from the request inputs.
  always_comb begin
    sout_en = (state == SHIFT);
    sout    = sout_en && shreg[WIDTH-1];
    done    = sout_en && last_bit;
    busy    = !idle;
  end

endmodule
